// File: rtl/wasm_fetch.sv
// WebAssembly instruction fetch: reads a ROM window at pc, decodes the opcode
// and its LEB128 immediate, and hands one instruction at a time to the core.
module wasm_fetch #(
  parameter int MEM_DEPTH = 3,
  parameter int MEM_EXTRA = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pc_load,
  input  logic [MEM_DEPTH:0]          pc_value,
  output logic [MEM_DEPTH:0]          mem_addr,
  output logic [MEM_EXTRA-1:0]        mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0] mem_data,
  input  logic                        mem_error,
  output logic                        insn_valid,
  input  logic                        insn_ready,
  output logic [7:0]                  insn_opcode,
  output logic [63:0]                 insn_imm,
  output logic [MEM_DEPTH:0]          insn_pc,
  output logic [3:0]                  insn_len,
  output logic [3:0]                  trap
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2**MEM_EXTRA) * 8;

  typedef enum logic [2:0] {FETCH, WAIT, DECODE, HOLD, TRAP} state_t;

  state_t        state, state_d;
  logic [AW-1:0] pc;
  logic [87:0]   win;
  logic [7:0]    opc, b;
  logic [63:0]   imm_d;
  logic [3:0]    len_d, max_b;
  logic          sgn, done, bad_d;
  logic          unused_data;

  // Only the longest encoding (11 bytes) of the window is ever decoded.
  assign unused_data = ^mem_data[DW-1:88];

  assign mem_addr   = pc;
  assign mem_extra  = '1;
  assign insn_valid = (state == HOLD);
  assign opc        = win[7:0];

  always_comb begin
    imm_d = '0;
    len_d = 4'd1;
    bad_d = 1'b0;
    done  = 1'b0;
    sgn   = 1'b0;
    b     = '0;
    case (opc)
      8'h41:                                     begin max_b = 4'd5;  sgn = 1'b1; end
      8'h42:                                     begin max_b = 4'd10; sgn = 1'b1; end
      8'h0C, 8'h0D, 8'h10, 8'h20, 8'h21, 8'h22,
      8'h23, 8'h24:                              max_b = 4'd5;
      default:                                   max_b = 4'd0;
    endcase
    for (int k = 0; k < 10; k++) begin
      if (!done && k < int'(max_b)) begin
        b     = win[8*(k+1) +: 8];
        imm_d = imm_d | ({57'd0, b[6:0]} << (7*k));
        if (!b[7]) begin
          done  = 1'b1;
          len_d = 4'(k + 2);
          if (sgn && (7*(k+1) < 64) && b[6])
            imm_d = imm_d | (~64'd0 << (7*(k+1)));
        end
      end
    end
    // Continuation still set on the last permitted byte.
    if (max_b != 4'd0 && !done) bad_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FETCH:   state_d = WAIT;
      WAIT:    state_d = mem_error ? TRAP : DECODE;
      DECODE:  state_d = bad_d ? TRAP : HOLD;
      HOLD:    if (insn_ready) state_d = FETCH;
      default: state_d = TRAP;
    endcase
    if (pc_load && state != TRAP) state_d = FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      win         <= '0;
      insn_opcode <= '0;
      insn_imm    <= '0;
      insn_pc     <= '0;
      insn_len    <= '0;
      trap        <= '0;
    end else if (state != TRAP) begin
      if (state == WAIT) win <= mem_data[87:0];
      // A redirect discards anything in flight, including a pending trap.
      if (pc_load) pc <= pc_value;
      else begin
        case (state)
          WAIT:   if (mem_error) trap <= 4'd1;
          DECODE: begin
            if (bad_d) trap <= 4'd2;
            else begin
              insn_opcode <= opc;
              insn_imm    <= imm_d;
              insn_len    <= len_d;
              insn_pc     <= pc;
            end
          end
          HOLD:   if (insn_ready) pc <= pc + AW'(insn_len);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wasm_fetch.sv
// Directed bench for wasm_fetch: table of encodings plus hand-written
// sequences for backpressure, redirects, traps and reset.
module tb_wasm_fetch;

  logic         clk = 1'b0, reset = 1'b1, pc_load = 1'b0, insn_ready = 1'b0;
  logic         mem_error, err_all = 1'b0;
  logic [3:0]   pc_value = '0;
  logic [3:0]   mem_addr, insn_pc, insn_len, trap, mem_extra;
  logic [127:0] mem_data;
  logic         insn_valid;
  logic [7:0]   insn_opcode;
  logic [63:0]  insn_imm;
  logic [7:0]   rom [16];
  int           n_chk = 0, n_fail = 0;
  int           cyc;

  typedef struct {
    logic [87:0] bytes;  // byte 0 in the top 8 bits
    logic [7:0]  op;
    logic [63:0] imm;
    logic [3:0]  len;
    logic [3:0]  trp;
  } vec_t;
  vec_t vecs [15];

  wasm_fetch dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .pc_value(pc_value),
    .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_data(mem_data),
    .mem_error(mem_error), .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_opcode(insn_opcode), .insn_imm(insn_imm), .insn_pc(insn_pc),
    .insn_len(insn_len), .trap(trap)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM with wrapping window.
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++) mem_data[8*k +: 8] <= rom[(int'(mem_addr) + k) % 16];
    mem_error <= err_all;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [87:0] bv);
    for (int k = 0; k < 16; k++) rom[k] = (k < 11) ? bv[87-8*k -: 8] : 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pc_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_evt(input string nm, output int c);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; c++;
      if (insn_valid || trap != 4'd0) break;
    end
    if (!insn_valid && trap == 4'd0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no valid or trap after %0d cycles", nm, c);
    end
  endtask

  initial begin
    vecs[0]  = '{88'h41_7F_00_00_00_00_00_00_00_00_00, 8'h41, 64'hFFFFFFFFFFFFFFFF, 4'd2,  4'd0};
    vecs[1]  = '{88'h41_3F_00_00_00_00_00_00_00_00_00, 8'h41, 64'h000000000000003F, 4'd2,  4'd0};
    vecs[2]  = '{88'h41_80_01_00_00_00_00_00_00_00_00, 8'h41, 64'h0000000000000080, 4'd3,  4'd0};
    vecs[3]  = '{88'h41_80_7F_00_00_00_00_00_00_00_00, 8'h41, 64'hFFFFFFFFFFFFFF80, 4'd3,  4'd0};
    vecs[4]  = '{88'h42_80_80_80_80_80_80_80_80_80_01, 8'h42, 64'h8000000000000000, 4'd11, 4'd0};
    vecs[5]  = '{88'h20_05_00_00_00_00_00_00_00_00_00, 8'h20, 64'h0000000000000005, 4'd2,  4'd0};
    vecs[6]  = '{88'h10_FF_01_00_00_00_00_00_00_00_00, 8'h10, 64'h00000000000000FF, 4'd3,  4'd0};
    vecs[7]  = '{88'h0C_7F_00_00_00_00_00_00_00_00_00, 8'h0C, 64'h000000000000007F, 4'd2,  4'd0};
    vecs[8]  = '{88'h0B_FF_00_00_00_00_00_00_00_00_00, 8'h0B, 64'h0000000000000000, 4'd1,  4'd0};
    vecs[9]  = '{88'h41_FF_FF_FF_FF_0F_00_00_00_00_00, 8'h41, 64'h00000000FFFFFFFF, 4'd6,  4'd0};
    vecs[10] = '{88'h41_FF_FF_FF_FF_7F_00_00_00_00_00, 8'h41, 64'hFFFFFFFFFFFFFFFF, 4'd6,  4'd0};
    vecs[11] = '{88'h24_80_80_80_80_00_00_00_00_00_00, 8'h24, 64'h0000000000000000, 4'd6,  4'd0};
    vecs[12] = '{88'h0D_FF_FF_FF_FF_7F_00_00_00_00_00, 8'h0D, 64'h00000007FFFFFFFF, 4'd6,  4'd0};
    vecs[13] = '{88'h20_80_80_80_80_80_00_00_00_00_00, 8'h00, 64'h0,                4'd0,  4'd2};
    vecs[14] = '{88'h42_80_80_80_80_80_80_80_80_80_80, 8'h00, 64'h0,                4'd0,  4'd2};

    load(88'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid",  64'(insn_valid),  64'd0);
    chk("rst opcode", 64'(insn_opcode), 64'd0);
    chk("rst imm",    insn_imm,         64'd0);
    chk("rst pc",     64'(insn_pc),     64'd0);
    chk("rst len",    64'(insn_len),    64'd0);
    chk("rst trap",   64'(trap),        64'd0);
    chk("rst addr",   64'(mem_addr),    64'd0);
    chk("rst extra",  64'(mem_extra),   64'hF);

    for (int i = 0; i < 15; i++) begin
      load(vecs[i].bytes);
      insn_ready = 1'b0;
      do_reset();
      wait_evt($sformatf("v%0d", i), cyc);
      chk($sformatf("v%0d trap", i), 64'(trap), 64'(vecs[i].trp));
      if (vecs[i].trp == 4'd0) begin
        chk($sformatf("v%0d latency", i), 64'(cyc),         64'd3);
        chk($sformatf("v%0d opcode", i),  64'(insn_opcode), 64'(vecs[i].op));
        chk($sformatf("v%0d imm", i),     insn_imm,         vecs[i].imm);
        chk($sformatf("v%0d len", i),     64'(insn_len),    64'(vecs[i].len));
        chk($sformatf("v%0d pc", i),      64'(insn_pc),     64'd0);
      end else begin
        @(negedge clk); pc_load = 1'b1; pc_value = 4'd3;
        @(negedge clk); pc_load = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk($sformatf("v%0d trap sticky", i), 64'(trap),       64'(vecs[i].trp));
          chk($sformatf("v%0d no valid", i),    64'(insn_valid), 64'd0);
          chk($sformatf("v%0d pc frozen", i),   64'(mem_addr),   64'd0);
        end
      end
    end

    // Back-to-back with ready held high: 41 7F then 0B at pc 2.
    load(88'h41_7F_0B_00_00_00_00_00_00_00_00);
    insn_ready = 1'b1;
    do_reset();
    wait_evt("seqA1", cyc);
    chk("A1 latency", 64'(cyc),         64'd3);
    chk("A1 opcode",  64'(insn_opcode), 64'h41);
    chk("A1 imm",     insn_imm,         64'hFFFFFFFFFFFFFFFF);
    chk("A1 len",     64'(insn_len),    64'd2);
    wait_evt("seqA2", cyc);
    chk("A2 gap",     64'(cyc),         64'd4);
    chk("A2 opcode",  64'(insn_opcode), 64'h0B);
    chk("A2 imm",     insn_imm,         64'd0);
    chk("A2 len",     64'(insn_len),    64'd1);
    chk("A2 pc",      64'(insn_pc),     64'd2);
    insn_ready = 1'b0;

    // Backpressure: outputs and address stable until the accept edge.
    load(88'h20_05_0B_00_00_00_00_00_00_00_00);
    do_reset();
    wait_evt("seqB", cyc);
    repeat (5) begin
      @(posedge clk); #1;
      chk("B hold valid",  64'(insn_valid),  64'd1);
      chk("B hold opcode", 64'(insn_opcode), 64'h20);
      chk("B hold imm",    insn_imm,         64'd5);
      chk("B hold addr",   64'(mem_addr),    64'd0);
    end
    @(negedge clk); insn_ready = 1'b1;
    @(posedge clk); #1;
    chk("B accept valid", 64'(insn_valid), 64'd0);
    chk("B accept addr",  64'(mem_addr),   64'd2);
    @(negedge clk); insn_ready = 1'b0;
    wait_evt("seqB2", cyc);
    chk("B2 opcode", 64'(insn_opcode), 64'h0B);
    chk("B2 pc",     64'(insn_pc),     64'd2);
    // Reset while holding an instruction.
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("B midhold valid",  64'(insn_valid),  64'd0);
    chk("B midhold opcode", 64'(insn_opcode), 64'd0);
    chk("B midhold pc",     64'(insn_pc),     64'd0);

    // Redirect during WAIT: nothing from pc 0 may be emitted.
    load(88'h42_01_00_00_00_00_00_00_00_00_00);
    rom[5] = 8'h41; rom[6] = 8'h3F;
    do_reset();
    @(posedge clk); #1;
    @(negedge clk); pc_load = 1'b1; pc_value = 4'd5;
    @(posedge clk); #1;
    chk("C redirect valid", 64'(insn_valid), 64'd0);
    chk("C redirect addr",  64'(mem_addr),   64'd5);
    @(negedge clk); pc_load = 1'b0;
    wait_evt("seqC", cyc);
    chk("C pc",     64'(insn_pc),     64'd5);
    chk("C opcode", 64'(insn_opcode), 64'h41);
    chk("C imm",    insn_imm,         64'h3F);

    // Redirect coincident with a handshake wins over pc+len.
    load(88'h0B_00_00_00_00_00_00_00_00_00_00);
    rom[9] = 8'h20; rom[10] = 8'h07;
    do_reset();
    wait_evt("seqE1", cyc);
    @(negedge clk); insn_ready = 1'b1; pc_load = 1'b1; pc_value = 4'd9;
    @(posedge clk); #1;
    chk("E addr",  64'(mem_addr),   64'd9);
    chk("E valid", 64'(insn_valid), 64'd0);
    @(negedge clk); insn_ready = 1'b0; pc_load = 1'b0;
    wait_evt("seqE2", cyc);
    chk("E pc",  64'(insn_pc),  64'd9);
    chk("E imm", insn_imm,      64'd7);
    chk("E len", 64'(insn_len), 64'd2);

    // ROM error trap, sticky against redirect, cleared by reset.
    load(88'h0B_00_00_00_00_00_00_00_00_00_00);
    err_all = 1'b1;
    do_reset();
    wait_evt("seqD", cyc);
    chk("D trap",    64'(trap),       64'd1);
    chk("D latency", 64'(cyc),        64'd2);
    chk("D valid",   64'(insn_valid), 64'd0);
    @(negedge clk); pc_load = 1'b1; pc_value = 4'd7;
    @(negedge clk); pc_load = 1'b0;
    @(posedge clk); #1;
    chk("D sticky trap", 64'(trap),     64'd1);
    chk("D sticky addr", 64'(mem_addr), 64'd0);
    err_all = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("D clear trap", 64'(trap),     64'd0);
    chk("D clear addr", 64'(mem_addr), 64'd0);
    @(negedge clk); reset = 1'b0;
    wait_evt("seqD2", cyc);
    chk("D refetch valid", 64'(insn_valid),  64'd1);
    chk("D refetch pc",    64'(insn_pc),     64'd0);
    chk("D refetch op",    64'(insn_opcode), 64'h0B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
